// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   RV32I fetch front end. It owns the fetch PC, runs a single-outstanding
//   request/response handshake with instruction memory, and buffers returned
//   words in an in-order prefetch queue of QDEPTH entries. The queue head is
//   presented to decode as {instruction, PC, PC+4}. A retired instruction
//   with pc_sel set redirects fetch to the ALU target.
//
//   Optional feature macro: IFU_PERF_COUNTERS_EN (adds performance counters).
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   o_imem_req/addr    fetch request and address
//   i_imem_ready       memory accepts the request this cycle
//   i_imem_rvalid/data response valid and instruction word
//   o_instr/o_pc       queue head instruction and its PC (NOP when empty)
//   o_pc_four          o_pc + 4
//   o_instr_vld        queue non-empty
//   i_instr_ack        consumer retires the head instruction
//   i_pc_sel           redirect request, qualified by ack and valid
//   i_alu_data         redirect target
//   o_perf_*           (IFU_PERF_COUNTERS_EN only) fetched/killed/stall counts
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_four,
   output logic        o_instr_vld,
   input  logic        i_instr_ack,
   input  logic        i_pc_sel,
   input  logic [31:0] i_alu_data
`ifdef IFU_PERF_COUNTERS_EN
   ,
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_killed,
   output logic [31:0] o_perf_stall
`endif
);

   localparam int unsigned PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PW:0]   DEPTH   = (PW+1)'(QDEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q;
   logic          out_q, out_d;
   logic          kill_q, kill_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]   cnt_q, cnt_d;

   logic [31:0]   instr_mem_q [QDEPTH];
   logic [31:0]   pc_mem_q    [QDEPTH];

   logic vld, redirect, pop, accept, resp, push, credit;

   assign vld      = (cnt_q != '0);
   assign redirect = i_instr_ack & i_pc_sel & vld;
   assign pop      = vld & i_instr_ack;
   assign resp     = i_imem_rvalid & out_q;
   // A response that meets a pending kill or a same-cycle redirect is stale.
   assign push     = resp & ~kill_q & ~redirect;
   assign credit   = ({1'b0, cnt_q} + {{(PW+1){1'b0}}, out_q}) < {1'b0, DEPTH};

   // Request is withdrawn combinationally in a redirect cycle, and held low
   // while reset is asserted even though the FSM already sits in REQ.
   assign o_imem_req  = i_rst_n & (state_q == S_REQ) & ~redirect;
   assign o_imem_addr = pc_q;
   assign accept      = o_imem_req & i_imem_ready;

   assign o_instr_vld = vld;
   assign o_instr     = vld ? instr_mem_q[rd_q] : NOP;
   assign o_pc        = vld ? pc_mem_q[rd_q]    : pc_q;
   assign o_pc_four   = o_pc + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q;
      kill_d  = kill_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;

      if (pop)  rd_d = rd_q + PTR_ONE;
      if (push) wr_d = wr_q + PTR_ONE;
      if (push & ~pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop & ~push) cnt_d = cnt_q - CNT_ONE;

      if (resp) begin
         out_d  = 1'b0;
         kill_d = 1'b0;
      end
      if (accept) begin
         out_d = 1'b1;
         pc_d  = pc_q + 32'd4;
      end

      case (state_q)
         S_IDLE:  if (credit) state_d = S_REQ;
         S_REQ:   if (accept) state_d = S_WAIT;
         S_WAIT:  if (resp)   state_d = (cnt_d < DEPTH) ? S_REQ : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Redirect overrides everything above: flush, retarget, and remember
      // whether a stale response is still in flight.
      if (redirect) begin
         cnt_d   = '0;
         rd_d    = '0;
         wr_d    = '0;
         pc_d    = i_alu_data & 32'hFFFF_FFFE;
         kill_d  = out_q & ~resp;
         state_d = out_d ? S_WAIT : S_REQ;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         out_q    <= 1'b0;
         kill_q   <= 1'b0;
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         kill_q  <= kill_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         if (accept) req_pc_q <= pc_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         instr_mem_q[wr_q] <= i_imem_rdata;
         pc_mem_q[wr_q]    <= req_pc_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n) assert (!(push && !pop && cnt_q == DEPTH));
   end

`ifdef IFU_PERF_COUNTERS_EN
   logic        drop;
   logic [31:0] killed_inc;
   logic [31:0] fetched_q, killed_q, stall_q;

   assign drop = resp & (kill_q | redirect);

   // Flushed words exclude the head, which retires rather than being killed.
   always_comb begin
      killed_inc = '0;
      if (redirect) killed_inc = 32'(cnt_q) - 32'd1;
      if (drop)     killed_inc = killed_inc + 32'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fetched_q <= '0;
         killed_q  <= '0;
         stall_q   <= '0;
      end else begin
         if (push) fetched_q <= fetched_q + 32'd1;
         killed_q <= killed_q + killed_inc;
         if (!vld) stall_q <= stall_q + 32'd1;
      end
   end

   assign o_perf_fetched = fetched_q;
   assign o_perf_killed  = killed_q;
   assign o_perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed scenarios followed by a randomized run. A memory model answers
//   one request at a time; a queue-based reference model predicts the
//   instruction stream (program order from the fetch start, restarting at
//   each redirect target) and the fetch address sequence.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          QDEPTH = 2;

   logic        i_clk, i_rst_n;
   logic        o_imem_req, o_imem_req2;
   logic [31:0] o_imem_addr, o_imem_addr2;
   logic        i_imem_ready, i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_instr, o_pc, o_pc_four, o_instr2, o_pc2, o_pc_four2;
   logic        o_instr_vld, o_instr_vld2;
   logic        i_instr_ack, i_pc_sel;
   logic [31:0] i_alu_data;
`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0] pf1, pk1, ps1, pf2, pk2, ps2;
`endif

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid),
      .i_imem_rdata(i_imem_rdata),
      .o_instr(o_instr), .o_pc(o_pc), .o_pc_four(o_pc_four),
      .o_instr_vld(o_instr_vld), .i_instr_ack(i_instr_ack),
      .i_pc_sel(i_pc_sel), .i_alu_data(i_alu_data)
`ifdef IFU_PERF_COUNTERS_EN
      , .o_perf_fetched(pf1), .o_perf_killed(pk1), .o_perf_stall(ps1)
`endif
   );

   // Wrap-around instance; timing-identical to dut, only addresses differ.
   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(QDEPTH)) dut2 (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .o_imem_req(o_imem_req2), .o_imem_addr(o_imem_addr2),
      .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid),
      .i_imem_rdata(i_imem_rdata),
      .o_instr(o_instr2), .o_pc(o_pc2), .o_pc_four(o_pc_four2),
      .o_instr_vld(o_instr_vld2), .i_instr_ack(i_instr_ack),
      .i_pc_sel(i_pc_sel), .i_alu_data(i_alu_data)
`ifdef IFU_PERF_COUNTERS_EN
      , .o_perf_fetched(pf2), .o_perf_killed(pk2), .o_perf_stall(ps2)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_pass = 0;
   int n_total = 0;

   // memory model
   bit          rdy_rand, lat_rand;
   int          fixed_lat;
   bit          mem_pend;
   int          mem_wait;
   logic [31:0] mem_addr;
   logic [31:0] pend_exp;

   // reference model
   logic [31:0] mq[$];
   logic [31:0] fetch_exp;
   bit          stale;
   logic [31:0] acc_log[$], acc2_log[$], ret_log[$], ret_cyc[$];
   logic [31:0] cyc, redir_cyc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
   endfunction

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
      i_instr_ack = 1'b0; i_pc_sel = 1'b0; i_alu_data = '0;
      mem_pend = 0; stale = 0; fetch_exp = 32'h0;
      mq.delete(); acc_log.delete(); acc2_log.delete();
      ret_log.delete(); ret_cyc.delete();
      cyc = 0; redir_cyc = 0;
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   task automatic step(input bit ack, input bit sel, input logic [31:0] alu);
      bit rv, vld_m, retire, redir, acc, acc2;
      @(posedge i_clk); #1;
      i_instr_ack = ack; i_pc_sel = sel; i_alu_data = alu;
      i_imem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rv = 0;
      if (mem_pend) begin
         mem_wait--;
         if (mem_wait == 0) rv = 1;
      end
      i_imem_rvalid = rv;
      i_imem_rdata  = rv ? memf(mem_addr) : $urandom;
      #3;
      vld_m = (mq.size() != 0);
      chk("vld", 32'(o_instr_vld), 32'(vld_m));
      if (vld_m) begin
         chk("head_pc", o_pc, mq[0]);
         chk("head_instr", o_instr, memf(mq[0]));
         chk("pc_four", o_pc_four, mq[0] + 32'd4);
      end else begin
         chk("empty_nop", o_instr, NOP);
      end
      retire = ack & vld_m;
      redir  = retire & sel;
      if (redir || (mq.size() + (mem_pend ? 1 : 0) >= QDEPTH))
         chk("req_off", 32'(o_imem_req), 32'h0);
      if (o_imem_req) chk("fetch_addr", o_imem_addr, fetch_exp);
      acc  = o_imem_req & i_imem_ready;
      acc2 = o_imem_req2 & i_imem_ready;

      if (retire) begin
         ret_log.push_back(mq[0]);
         ret_cyc.push_back(cyc);
         void'(mq.pop_front());
      end
      if (redir) begin
         mq.delete();
         redir_cyc = cyc;
      end
      if (rv) begin
         mem_pend = 0;
         if (!stale && !redir) mq.push_back(pend_exp);
         stale = 0;
      end
      if (acc) begin
         acc_log.push_back(o_imem_addr);
         mem_pend = 1;
         mem_addr = o_imem_addr;
         pend_exp = fetch_exp;
         mem_wait = lat_rand ? int'($urandom_range(1, 3)) : fixed_lat;
         fetch_exp = fetch_exp + 32'd4;
      end
      if (acc2) acc2_log.push_back(o_imem_addr2);
      if (redir) begin
         fetch_exp = alu & 32'hFFFF_FFFE;
         if (mem_pend) stale = 1;
      end
      cyc++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int na, nr;
      rdy_rand = 0; lat_rand = 0; fixed_lat = 1;

      // A: streaming with ready=1, latency 1, ack=1
      do_reset();
      chk("rst_req", 32'(o_imem_req), 32'h0);
      chk("rst_vld", 32'(o_instr_vld), 32'h0);
      chk("rst_instr", o_instr, NOP);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_pc_four", o_pc_four, 32'h4);
      chk("rst2_pc", o_pc2, 32'hFFFF_FFFC);
      chk("rst2_pc_four", o_pc_four2, 32'h0);
      i_rst_n = 1'b1;
      repeat (12) step(1, 0, 0);
      chk("A_addr0", qat(acc_log, 0), 32'h0);
      chk("A_addr1", qat(acc_log, 1), 32'h4);
      chk("A_addr2", qat(acc_log, 2), 32'h8);
      chk("A_first_pc", qat(ret_log, 0), 32'h0);
      chk("A_first_cyc", qat(ret_cyc, 0), 32'd2);
      chk("A_gap1", qat(ret_cyc, 1) - qat(ret_cyc, 0), 32'd2);
      chk("A_gap2", qat(ret_cyc, 2) - qat(ret_cyc, 1), 32'd2);
      chk("wrap_addr0", qat(acc2_log, 0), 32'hFFFF_FFFC);
      chk("wrap_addr1", qat(acc2_log, 1), 32'h0);

      // B: ack held low fills the queue, then drains
      do_reset();
      i_rst_n = 1'b1;
      repeat (10) step(0, 0, 0);
      chk("B_idle_req", 32'(o_imem_req), 32'h0);
      chk("B_vld", 32'(o_instr_vld), 32'h1);
      chk("B_head", o_pc, 32'h0);
      chk("B_nfetch", acc_log.size(), 32'd2);
      repeat (6) step(1, 0, 0);
      chk("B_ret0", qat(ret_log, 0), 32'h0);
      chk("B_ret1", qat(ret_log, 1), 32'h4);
      chk("B_resume", qat(acc_log, 2), 32'h8);

      // C: redirect while the request for 0x8 is outstanding
      do_reset();
      i_rst_n = 1'b1;
      fixed_lat = 3;
      for (int i = 0; i < 40 && acc_log.size() < 3; i++) step(mq.size() == 2, 0, 0);
      chk("C_reach", qat(acc_log, 2), 32'h8);
      step(1, 1, 32'h0000_0101);
      na = acc_log.size();
      nr = ret_log.size();
      fixed_lat = 1;
      repeat (12) step(1, 0, 0);
      chk("C_new_addr", qat(acc_log, na), 32'h0000_0100);
      chk("C_new_pc", qat(ret_log, nr), 32'h0000_0100);
      chk("C_latency", 32'((qat(ret_cyc, nr) - redir_cyc) >= 32'd2), 32'h1);

      // D: redirect coincides with a response
      do_reset();
      i_rst_n = 1'b1;
      repeat (3) step(0, 0, 0);
      step(1, 1, 32'h0000_0200);
      step(0, 0, 0);
      chk("D_vld", 32'(o_instr_vld), 32'h0);
      chk("D_nop", o_instr, NOP);
      na = acc_log.size();
      nr = ret_log.size();
      repeat (6) step(1, 0, 0);
      chk("D_new_pc", qat(ret_log, nr), 32'h0000_0200);

      // E: asynchronous reset mid-WAIT
      do_reset();
      i_rst_n = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      fixed_lat = 3;
      step(0, 0, 0);
      step(0, 0, 0);
      chk("E_pre_vld", 32'(o_instr_vld), 32'h1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("E_req", 32'(o_imem_req), 32'h0);
      chk("E_vld", 32'(o_instr_vld), 32'h0);
      chk("E_instr", o_instr, NOP);
      chk("E_pc", o_pc, 32'h0);
      chk("E_pc_four", o_pc_four, 32'h4);
      chk("E_addr", o_imem_addr, 32'h0);
      fixed_lat = 1;
      do_reset();
      i_rst_n = 1'b1;
      step(1, 0, 0);
      chk("E_refetch", qat(acc_log, 0), 32'h0);

      // F: randomized traffic
      do_reset();
      i_rst_n = 1'b1;
      rdy_rand = 1; lat_rand = 1;
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom & 32'h0000_3FFF);
      chk("F_progress", 32'(ret_log.size() > 100), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the RISC-V RV32I core. Owns the fetch PC and runs the request/response handshake with instruction memory.
- Buffers fetched words in a small in-order prefetch queue. Presents {instruction, PC, PC+4} to the decode/control stage.
- Consumes the control stage's pc_sel plus the ALU-computed target to redirect fetch on taken branches, JAL and JALR.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, prefetch queue entries; power of 2, at least 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  32  fetch address, word aligned.
- i_imem_ready  in  1  memory accepts the request this cycle.
- i_imem_rvalid  in  1  response data valid.
- i_imem_rdata  in  32  response instruction word.
- o_instr  out  32  instruction at queue head; drives the control unit's i_instr.
- o_pc  out  32  PC of o_instr.
- o_pc_four  out  32  o_pc + 4; used for wb_sel=2'b10.
- o_instr_vld  out  1  queue non-empty.
- i_instr_ack  in  1  consumer retires head instruction this cycle.
- i_pc_sel  in  1  redirect request from control unit; qualified by i_instr_ack.
- i_alu_data  in  32  redirect target.

Behaviour:
Reset (async assert, sync release):
- Queue empty; outstanding=0; kill=0; fetch PC = RESET_PC; state REQ.
- o_imem_req=0 during reset, o_instr_vld=0, o_instr=32'h0000_0013 (NOP), o_pc=RESET_PC, o_pc_four=RESET_PC+4.
- Any in-flight memory response is lost; memory shares the same reset.

FSM states:
- IDLE: no credit; o_imem_req=0.
- REQ: o_imem_req=1, o_imem_addr=fetch PC.
- WAIT: one request outstanding, awaiting rvalid.

Credit rule:
- credit = (count + outstanding) < QDEPTH.
- IDLE->REQ when credit.
- REQ->WAIT on i_imem_ready: fetch PC += 4 (wraps modulo 2^32), outstanding=1.
- WAIT->REQ on i_imem_rvalid if credit after the push, else WAIT->IDLE.
- Maximum one outstanding request.
- Responses arrive at least 1 cycle after acceptance, in order.

Response handling:
- On i_imem_rvalid with kill=0, push {rdata, PC of request} into the queue.
- On i_imem_rvalid with kill=1, drop the word and clear kill.

Output and retire:
- o_instr/o_pc come from the queue head.
- When the queue is empty: o_instr=32'h0000_0013, o_instr_vld=0.
- Pop when o_instr_vld & i_instr_ack.
- Push and pop in the same cycle: count unchanged.

Redirect (i_instr_ack & i_pc_sel & o_instr_vld):
- Flush the queue.
- Fetch PC <= i_alu_data & 32'hFFFF_FFFE, with bit 1 retained.
- If a request is outstanding, set kill. A response in the same cycle as the redirect is also dropped.
- If in REQ and not yet accepted, the request is withdrawn. The memory protocol permits withdrawal; ready is only meaningful when req=1.
- No request is issued in the redirect cycle. Next cycle: state REQ if no outstanding, else WAIT.
- First redirected instruction becomes valid at least 2 cycles after the redirect cycle.
- i_pc_sel without ack/valid is ignored.

Invariants:
- o_imem_addr is stable while o_imem_req=1 and not accepted, except on redirect.
- Queue overflow is impossible by the credit rule; a push when full is a design error, caught by assertion.

Optional Feature:
- Macro: IFU_PERF_COUNTERS_EN.
- When defined, adds ports:
  - o_perf_fetched, out, 32: count of pushed words.
  - o_perf_killed, out, 32: count of words dropped via kill or flush.
  - o_perf_stall, out, 32: cycles with o_instr_vld=0.
- All counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset, memory ready=1, 1-cycle latency, ack=1 always:
  - o_imem_addr sequence 0x0, 0x4, 0x8.
  - First o_instr_vld=1 with o_pc=0x0, o_pc_four=0x4.
  - Thereafter one instruction every 2 cycles.
- Ack held 0: after 2 fetches o_imem_req=0 (IDLE), o_instr_vld=1, head PC=0x0. Release ack: pops 0x0 then 0x4, fetch resumes at 0x8.
- Redirect with i_alu_data=0x0000_0101 while the request for 0x8 is outstanding:
  - Response for 0x8 dropped.
  - Next o_imem_addr=0x0000_0100.
  - Next valid o_pc=0x100.
- Redirect in the same cycle as i_imem_rvalid: word dropped, queue empty, o_instr=32'h0000_0013, o_instr_vld=0.
- RESET_PC=32'hFFFF_FFFC: second fetch address wraps to 0x0000_0000.
- Assert i_rst_n=0 mid-WAIT: all outputs return to reset values immediately (asynchronously); after release, first fetch at RESET_PC.
